// File: rtl/fuzz_pkg.sv
// Shared definitions for the fuzz stimulus engine.
//   LCG_MUL / LCG_INC : team LCG constants, s' = s*LCG_MUL + LCG_INC (mod 2^32)
//   MISR_POLY_DEF     : default MISR feedback polynomial
//   FOLD_MAX          : widest response fold32() accepts (callers zero-extend)
//   fuzz_state_e      : engine FSM states
//   lcg_next()        : one LCG step
//   fold32()          : XOR of 32-bit chunks; zero-extension pads the last chunk
package fuzz_pkg;

  localparam logic [31:0] LCG_MUL       = 32'h41C6_4E6D;
  localparam logic [31:0] LCG_INC       = 32'h0000_3039;
  localparam logic [31:0] MISR_POLY_DEF = 32'h04C1_1DB7;
  localparam int          FOLD_MAX      = 4096;

  typedef enum logic [2:0] {IDLE, PRIME, RUN, DRAIN, DONE} fuzz_state_e;

  function automatic logic [31:0] lcg_next(input logic [31:0] s);
    return s * LCG_MUL + LCG_INC;
  endfunction

  // Zero chunks past the real response width leave the XOR unchanged, so one
  // fixed-width function serves every response width up to FOLD_MAX.
  function automatic logic [31:0] fold32(input logic [FOLD_MAX-1:0] v);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < FOLD_MAX / 32; i++) f ^= v[32*i +: 32];
    return f;
  endfunction

endpackage

// File: rtl/fuzz_misr.sv
// 32-bit MISR that folds an OUT_W response into one word per absorption.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : synchronous clear (wins over en_i)
//   en_i       : absorb fold32(resp_i) this cycle
//   resp_i     : DUT response, OUT_W bits
//   sig_o      : MISR state
module fuzz_misr import fuzz_pkg::*; #(
  parameter int          OUT_W     = 330,
  parameter logic [31:0] MISR_POLY = MISR_POLY_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [OUT_W-1:0] resp_i,
  output logic [31:0]      sig_o
);

  logic [31:0] sig_q, sig_d, fold;

  assign fold  = fold32(FOLD_MAX'(resp_i));
  assign sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'h0) ^ fold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     sig_q <= '0;
    else if (clr_i) sig_q <= '0;
    else if (en_i)  sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/fuzz_stim_engine.sv
// LCG stimulus generator with MISR response compaction for fuzz harnesses.
//   clk, rst_n  : clock, async active-low reset
//   start       : begin a run (IDLE/DONE only); samples seed and cycles
//   abort       : back to IDLE from anywhere, clears signature
//   hold        : stall LCG, word index, vector and drain counters
//   seed        : LCG seed
//   cycles      : vectors after the initial one
//   resp_flat   : DUT response
//   stim_flat   : vector driven to the DUT, changes only as a whole
//   stim_valid  : pulses the cycle stim_flat changes
//   busy / done : PRIME|RUN|DRAIN / DONE
//   vec_count   : vectors applied, saturating
//   signature   : MISR state
module fuzz_stim_engine import fuzz_pkg::*; #(
  parameter int          IN_W      = 263,
  parameter int          OUT_W     = 330,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] MISR_POLY = MISR_POLY_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] cycles,
  input  logic [OUT_W-1:0] resp_flat,
  output logic [IN_W-1:0]  stim_flat,
  output logic             stim_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_count,
  output logic [31:0]      signature
);

  localparam int NW     = (IN_W + 31) / 32;
  localparam int LAST_W = IN_W - 32 * (NW - 1);
  localparam int IDX_W  = (NW > 1) ? $clog2(NW) : 1;

  fuzz_state_e      state_q;
  logic [31:0]      lcg_q, s_nxt;
  logic [IDX_W-1:0] idx_q, drain_q;
  logic [CNT_W-1:0] rem_q, vec_count_q;
  logic [IN_W-1:0]  stim_q, vec_nxt;
  logic             valid_q, busy_q, done_q;
  logic             start_ok, step, last_word, drain_last, absorb;

  assign s_nxt      = lcg_next(lcg_q);
  assign start_ok   = start && (state_q == IDLE || state_q == DONE);
  assign step       = !abort && !hold && (state_q == PRIME || state_q == RUN);
  assign last_word  = (idx_q == IDX_W'(NW - 1));
  assign drain_last = (drain_q == IDX_W'(NW - 1));
  // The response to the current vector is absorbed on the edge that replaces
  // it (RUN) or after NW drain cycles (DRAIN).
  assign absorb     = !abort && !hold &&
                      ((state_q == RUN && last_word) || (state_q == DRAIN && drain_last));

  // The last word never sits in the shadow: it goes straight from the LCG
  // into stim_flat together with the shadowed words, so only whole vectors
  // are ever visible.
  if (NW > 1) begin : g_shadow
    logic [NW-2:0][31:0] shadow_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) shadow_q <= '0;
      else if (step && !last_word)
        for (int k = 0; k < NW - 1; k++)
          if (idx_q == IDX_W'(k)) shadow_q[k] <= s_nxt;
    end
    assign vec_nxt = {s_nxt[LAST_W-1:0], shadow_q};
  end else begin : g_single
    assign vec_nxt = s_nxt[LAST_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lcg_q       <= '0;
      idx_q       <= '0;
      drain_q     <= '0;
      rem_q       <= '0;
      vec_count_q <= '0;
      stim_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else if (start_ok) begin
        state_q     <= PRIME;
        lcg_q       <= seed;
        idx_q       <= '0;
        rem_q       <= cycles;
        vec_count_q <= '0;
        busy_q      <= 1'b1;
        done_q      <= 1'b0;
      end else if (!hold) begin
        unique case (state_q)
          PRIME, RUN: begin
            lcg_q <= s_nxt;
            if (last_word) begin
              idx_q       <= '0;
              stim_q      <= vec_nxt;
              valid_q     <= 1'b1;
              vec_count_q <= (&vec_count_q) ? vec_count_q : vec_count_q + 1'b1;
              // rem_q counts RUN vectors still owed; decrementing only in RUN
              // keeps cycles = all-ones from overflowing a CNT_W counter.
              if (state_q == RUN) rem_q <= rem_q - 1'b1;
              if ((state_q == PRIME && rem_q == '0) ||
                  (state_q == RUN && rem_q == CNT_W'(1))) begin
                state_q <= DRAIN;
                drain_q <= '0;
              end else begin
                state_q <= RUN;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
          DRAIN: begin
            if (drain_last) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              drain_q <= drain_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  fuzz_misr #(.OUT_W(OUT_W), .MISR_POLY(MISR_POLY)) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (abort || start_ok),
    .en_i   (absorb),
    .resp_i (resp_flat),
    .sig_o  (signature)
  );

  assign stim_flat  = stim_q;
  assign stim_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign vec_count  = vec_count_q;

endmodule

// File: tb/tb_fuzz_stim_engine.sv
module tb_fuzz_stim_engine;

  logic         clk = 1'b0;
  logic         rst_n, start, abort, hold;
  logic [31:0]  seed, cycles;
  logic [329:0] resp;

  logic [262:0] stim_flat;
  logic         stim_valid, busy, done;
  logic [31:0]  vec_count, signature;

  logic [39:0]  s_stim;
  logic         s_valid, s_busy, s_done;
  logic [31:0]  s_vcnt, s_sig;

  always #5 clk = ~clk;

  fuzz_stim_engine u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold),
    .seed(seed), .cycles(cycles), .resp_flat(resp),
    .stim_flat(stim_flat), .stim_valid(stim_valid), .busy(busy), .done(done),
    .vec_count(vec_count), .signature(signature)
  );

  fuzz_stim_engine #(.IN_W(40), .OUT_W(40)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold),
    .seed(seed), .cycles(cycles), .resp_flat(resp[39:0]),
    .stim_flat(s_stim), .stim_valid(s_valid), .busy(s_busy), .done(s_done),
    .vec_count(s_vcnt), .signature(s_sig)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, last_cyc = 0, pulse_cnt = 0;
  int sm_pulses, sm_vlat, sm_dlat;
  bit chk_gap = 1'b0;
  logic [262:0] exp_q[$];
  logic [262:0] mon_first, mon_last;

  task automatic chk(input string tag, input logic [329:0] obs, input logic [329:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] blcg(input logic [31:0] s);
    return s * 32'h41C64E6D + 32'h3039;
  endfunction

  function automatic logic [31:0] bfold(input logic [329:0] r);
    logic [31:0] f = '0;
    for (int b = 0; b < 330; b++) f[b % 32] ^= r[b];
    return f;
  endfunction

  function automatic logic [31:0] bsig(input logic [329:0] r, input int n);
    logic [31:0] m = '0;
    for (int i = 0; i < n; i++)
      m = {m[30:0], 1'b0} ^ (m[31] ? 32'h04C11DB7 : 32'h0) ^ bfold(r);
    return m;
  endfunction

  task automatic push_exp(input logic [31:0] sd, input logic [31:0] nc);
    logic [31:0]  s = sd;
    logic [287:0] full;
    for (int v = 0; v <= int'(nc); v++) begin
      for (int w = 0; w < 9; w++) begin
        s = blcg(s);
        full[32*w +: 32] = s;
      end
      exp_q.push_back(full[262:0]);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: every vector the default engine applies must be the next
  // one the software LCG predicted.
  always @(negedge clk) begin
    if (rst_n && stim_valid) begin
      chk("vec_expected", 330'(exp_q.size() != 0), 330'(1));
      if (exp_q.size() != 0) begin
        mon_last = exp_q.pop_front();
        chk("stim_vec", 330'(stim_flat), 330'(mon_last));
      end
      if (pulse_cnt == 0) mon_first = stim_flat;
      if (chk_gap && pulse_cnt != 0) chk("gap", 330'(cyc - last_cyc), 330'(9));
      last_cyc = cyc;
      pulse_cnt++;
    end
  end

  task automatic run_case(input logic [31:0] sd, input logic [31:0] nc, input logic [329:0] r,
                          input int hold_at, input int hold_len, input int restart_at,
                          output int lat);
    push_exp(sd, nc);
    resp = r; seed = sd; cycles = nc;
    pulse_cnt = 0; sm_pulses = 0; sm_vlat = 0; sm_dlat = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 1;
    while (!done && lat < 3000) begin
      if (s_valid) begin sm_pulses++; sm_vlat = lat; end
      if (s_done && sm_dlat == 0) sm_dlat = lat;
      hold = (lat >= hold_at && lat < hold_at + hold_len);
      if (lat == restart_at) begin start = 1'b1; seed = ~sd; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    hold = 1'b0; start = 1'b0;
  endtask

  task automatic post(input string tg, input logic [31:0] nc, input logic [329:0] r,
                      input int lat, input int lat_exp);
    chk({tg, "_done"}, 330'(done), 330'(1));
    chk({tg, "_busy"}, 330'(busy), 330'(0));
    chk({tg, "_sig"},  330'(signature), 330'(bsig(r, int'(nc) + 1)));
    chk({tg, "_vcnt"}, 330'(vec_count), 330'(nc + 1));
    chk({tg, "_qempty"}, 330'(exp_q.size()), 330'(0));
    chk({tg, "_lat"}, 330'(lat), 330'(lat_exp));
  endtask

  task automatic chk_zero(input string tg);
    chk({tg, "_stim"},  330'(stim_flat), 330'(0));
    chk({tg, "_valid"}, 330'(stim_valid), 330'(0));
    chk({tg, "_busy"},  330'(busy), 330'(0));
    chk({tg, "_done"},  330'(done), 330'(0));
    chk({tg, "_vcnt"},  330'(vec_count), 330'(0));
    chk({tg, "_sig"},   330'(signature), 330'(0));
  endtask

  initial begin
    int lat, lat0, pc;
    logic [329:0] R, R2;
    logic [351:0] tmp;
    for (int i = 0; i < 11; i++) tmp[32*i +: 32] = $urandom;
    R = tmp[329:0];
    for (int i = 0; i < 11; i++) tmp[32*i +: 32] = $urandom;
    R2 = tmp[329:0];

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0;
    seed = '0; cycles = '0; resp = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // seed 0, cycles 0: single vector; done NW cycles after it
    run_case(32'd0, 32'd0, '0, -1, 0, -1, lat);
    chk("small_stim", 330'(s_stim), 330'(40'h7E_0000_3039));
    chk("small_pulses", 330'(sm_pulses), 330'(1));
    chk("small_done_delay", 330'(sm_dlat - sm_vlat), 330'(2));
    chk("small_vcnt", 330'(s_vcnt), 330'(1));
    chk("small_sig", 330'(s_sig), 330'(0));
    chk("small_busy", 330'(s_busy), 330'(0));
    post("c0", 32'd0, '0, lat, 9 * 2 + 1);

    // seed 1, 100 vectors spaced 9 cycles, zero response
    chk_gap = 1'b1;
    run_case(32'd1, 32'd99, '0, -1, 0, -1, lat);
    chk_gap = 1'b0;
    chk("first_word", 330'(mon_first[31:0]), 330'(32'h41C67EA6));
    chk("pulses100", 330'(pulse_cnt), 330'(100));
    post("c99", 32'd99, '0, lat, 9 * 101 + 1);

    // resp = 1, two absorptions -> 3; a start while busy must be ignored
    run_case(32'd5, 32'd1, 330'(1), -1, 0, 5, lat);
    chk("sig_resp1", 330'(signature), 330'(32'h3));
    post("c1", 32'd1, 330'(1), lat, 9 * 3 + 1);

    // hold: unheld reference, mid-vector hold of 5, drain hold of 3
    run_case(32'd7, 32'd3, R, -1, 0, -1, lat0);
    post("ref", 32'd3, R, lat0, 9 * 5 + 1);
    run_case(32'd7, 32'd3, R, 12, 5, -1, lat);
    post("hold5", 32'd3, R, lat, lat0 + 5);
    run_case(32'd7, 32'd3, R, 38, 3, -1, lat);
    post("hold_drain", 32'd3, R, lat, lat0 + 3);

    // abort mid-RUN after one absorption, then clean rerun with same seed
    push_exp(32'd11, 32'd5);
    resp = R; seed = 32'd11; cycles = 32'd5; pulse_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (22) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    exp_q.delete();
    chk("abort_busy", 330'(busy), 330'(0));
    chk("abort_done", 330'(done), 330'(0));
    chk("abort_sig", 330'(signature), 330'(0));
    chk("abort_stim", 330'(stim_flat), 330'(mon_last));
    chk("abort_pulses", 330'(pulse_cnt), 330'(2));
    pc = pulse_cnt;
    repeat (12) @(negedge clk);
    chk("abort_quiet", 330'(pulse_cnt), 330'(pc));
    run_case(32'd11, 32'd5, R, -1, 0, -1, lat);
    post("rerun", 32'd5, R, lat, 9 * 7 + 1);

    // asynchronous reset mid-RUN, then a run as from power-up
    push_exp(32'd9, 32'd4);
    resp = R2; seed = 32'd9; cycles = 32'd4;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (24) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    run_case(32'd3, 32'd2, R2, -1, 0, -1, lat);
    post("after_rst", 32'd2, R2, lat, 9 * 4 + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
